// File: rtl/conv_pkg.sv
// Shared sizes and FSM state type for the convolution stream feeder.
package conv_pkg;

    localparam int DATA_WIDTH_X = 8;
    localparam int DATA_WIDTH_F = 8;
    localparam int X_SIZE       = 128;
    localparam int F_SIZE       = 32;
    localparam int ACC_SIZE     = 21;
    localparam int Y_COUNT      = X_SIZE - F_SIZE + 1;
    localparam int SUM_SIZE     = ACC_SIZE + $clog2(Y_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    // Larger of two widths, used to size the shared load data bus.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_feeder_stream_src.sv
// One stream source: preloaded buffer, read index, fin flag and
// registered valid/data. Instantiated once for F and once for X.
module stream_src #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             launch,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             fin,
    output logic             last_beat
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    idx_r;
    logic [AW-1:0]    idx_next_s;
    logic             beat_s;

    assign beat_s     = valid && ready;
    assign idx_next_s = idx_r + IDX_ONE;
    assign last_beat  = beat_s && (idx_r == LAST_IDX);

    // Buffer writes; plain storage that survives reset so reruns repeat stimulus.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Index walk with registered valid/data; valid is held until the beat is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r <= '0;
            fin   <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else if (launch) begin
            idx_r <= '0;
            fin   <= 1'b0;
            valid <= 1'b1;
            data  <= mem_r[{AW{1'b0}}];
        end else if (beat_s) begin
            if (idx_r == LAST_IDX) begin
                fin   <= 1'b1;
                valid <= 1'b0;
                data  <= '0;
            end else begin
                idx_r <= idx_next_s;
                data  <= mem_r[idx_next_s];
            end
        end
    end

endmodule

// File: rtl/conv_feeder.sv
// Stream master around the 128x32 convolution engine: feeds F and X from
// preloaded buffers and collects the Y results into a count and checksum.
module conv_feeder #(
    parameter  int DATA_WIDTH_X = conv_pkg::DATA_WIDTH_X,
    parameter  int DATA_WIDTH_F = conv_pkg::DATA_WIDTH_F,
    parameter  int X_SIZE       = conv_pkg::X_SIZE,
    parameter  int F_SIZE       = conv_pkg::F_SIZE,
    parameter  int ACC_SIZE     = conv_pkg::ACC_SIZE,
    parameter  int Y_COUNT      = X_SIZE - F_SIZE + 1,
    parameter  int SUM_SIZE     = ACC_SIZE + $clog2(Y_COUNT),
    localparam int LD_W         = conv_pkg::max_int(DATA_WIDTH_X, DATA_WIDTH_F),
    localparam int XA           = $clog2(X_SIZE),
    localparam int FA           = $clog2(F_SIZE),
    localparam int YCW          = $clog2(Y_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    input  logic                    ld_sel,
    input  logic [XA-1:0]           ld_addr,
    input  logic [LD_W-1:0]         ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid_f,
    output logic [DATA_WIDTH_F-1:0] m_data_f,
    input  logic                    m_ready_f,
    output logic                    m_valid_x,
    output logic [DATA_WIDTH_X-1:0] m_data_x,
    input  logic                    m_ready_x,
    input  logic                    s_valid_y,
    input  logic [ACC_SIZE-1:0]     s_data_y,
    output logic                    s_ready_y,
    output logic [YCW-1:0]          y_count,
    output logic [SUM_SIZE-1:0]     y_sum
);

    import conv_pkg::*;

    localparam logic [YCW-1:0] Y_LAST = YCW'(Y_COUNT - 1);
    localparam logic [YCW-1:0] Y_FULL = YCW'(Y_COUNT);
    localparam logic [YCW-1:0] Y_ONE  = YCW'(1);

    feeder_state_t       state_r;
    logic                launch_s;
    logic                f_wr_s;
    logic                x_wr_s;
    logic                f_fin_s;
    logic                x_fin_s;
    logic                f_last_s;
    logic                x_last_s;
    logic                fins_next_s;
    logic                y_beat_s;
    logic                y_last_s;
    logic                y_done_next_s;
    logic [SUM_SIZE-1:0] y_ext_s;

    // Loads and run requests only count while idle.
    assign launch_s = start && (state_r == ST_IDLE);
    assign f_wr_s   = ld_valid && (state_r == ST_IDLE) && !ld_sel;
    assign x_wr_s   = ld_valid && (state_r == ST_IDLE) && ld_sel;

    // Both streams are finished now or finish on this edge.
    assign fins_next_s   = (f_fin_s || f_last_s) && (x_fin_s || x_last_s);
    assign y_beat_s      = s_valid_y && s_ready_y;
    assign y_last_s      = y_beat_s && (y_count == Y_LAST);
    assign y_done_next_s = y_last_s || (y_count == Y_FULL);
    assign y_ext_s       = {{(SUM_SIZE - ACC_SIZE){s_data_y[ACC_SIZE-1]}}, s_data_y};

    stream_src #(.DEPTH(F_SIZE), .WIDTH(DATA_WIDTH_F)) u_src_f (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (f_wr_s),
        .wr_addr   (ld_addr[FA-1:0]),
        .wr_data   (ld_data[DATA_WIDTH_F-1:0]),
        .launch    (launch_s),
        .ready     (m_ready_f),
        .valid     (m_valid_f),
        .data      (m_data_f),
        .fin       (f_fin_s),
        .last_beat (f_last_s)
    );

    stream_src #(.DEPTH(X_SIZE), .WIDTH(DATA_WIDTH_X)) u_src_x (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (x_wr_s),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data[DATA_WIDTH_X-1:0]),
        .launch    (launch_s),
        .ready     (m_ready_x),
        .valid     (m_valid_x),
        .data      (m_data_x),
        .fin       (x_fin_s),
        .last_beat (x_last_s)
    );

    // Run control FSM with Y collection; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            s_ready_y <= 1'b0;
            y_count   <= '0;
            y_sum     <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_STREAM;
                        busy      <= 1'b1;
                        s_ready_y <= 1'b1;
                        y_count   <= '0;
                        y_sum     <= '0;
                    end
                end
                ST_STREAM, ST_DRAIN: begin
                    if (y_beat_s) begin
                        y_count <= y_count + Y_ONE;
                        y_sum   <= y_sum + y_ext_s;
                        if (y_last_s) begin
                            s_ready_y <= 1'b0;
                        end
                    end
                    // Y may finish first; completion waits for both streams.
                    if (fins_next_s && y_done_next_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end else if ((state_r == ST_STREAM) && fins_next_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    s_ready_y <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed self-checking bench for conv_feeder.
module tb_conv_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_sel;
    logic [6:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        m_valid_f;
    logic [7:0]  m_data_f;
    logic        m_ready_f;
    logic        m_valid_x;
    logic [7:0]  m_data_x;
    logic        m_ready_x;
    logic        s_valid_y;
    logic [20:0] s_data_y;
    logic        s_ready_y;
    logic [6:0]  y_count;
    logic [27:0] y_sum;

    always #5 clk = ~clk;

    conv_feeder dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .busy(busy),
        .done(done), .m_valid_f(m_valid_f), .m_data_f(m_data_f),
        .m_ready_f(m_ready_f), .m_valid_x(m_valid_x), .m_data_x(m_data_x),
        .m_ready_x(m_ready_x), .s_valid_y(s_valid_y), .s_data_y(s_data_y),
        .s_ready_y(s_ready_y), .y_count(y_count), .y_sum(y_sum)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0] fmem [32];
    logic [7:0] xmem [128];

    // Observations gathered by run_stream.
    int f_beats, x_beats, f_ord_err, x_ord_err, stab_err, y_beats, y_extra_err;
    int done_pulses, done_cycle, f_last_c, x_last_c, y_last_c, hold_cycles, hold_err;
    bit busy_after, timed_out, start_ok;
    logic [55:0] rst_snap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: every entry = v; mode 1: distinct ramps, F written through wrapped addresses.
    task automatic load_bufs(input int mode, input logic [7:0] v);
        for (int i = 0; i < 32; i++) begin
            fmem[i]  = (mode == 0) ? v : 8'(i * 7 + 3);
            ld_valid = 1'b1;
            ld_sel   = 1'b0;
            ld_addr  = (mode == 0) ? 7'(i) : 7'(i + 32);
            ld_data  = fmem[i];
            tick();
        end
        for (int i = 0; i < 128; i++) begin
            xmem[i]  = (mode == 0) ? v : 8'(i * 5 + 11);
            ld_valid = 1'b1;
            ld_sel   = 1'b1;
            ld_addr  = 7'(i);
            ld_data  = xmem[i];
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic run_stream(input int x_period, input bit f_rand, input bit y_rand,
                              input logic [20:0] yval, input int x_stall_idx,
                              input bit y_last_with_x, input int poke_c, input int reset_at_x);
        bit   finished = 1'b0;
        bit   pf_stall = 1'b0;
        bit   px_stall = 1'b0;
        logic [7:0] pf_data = 8'h00;
        logic [7:0] px_data = 8'h00;
        int   stall_cnt = 0;
        f_beats = 0; x_beats = 0; f_ord_err = 0; x_ord_err = 0; stab_err = 0;
        y_beats = 0; y_extra_err = 0; done_pulses = 0; done_cycle = -1;
        f_last_c = -1; x_last_c = -1; y_last_c = -1; hold_cycles = 0; hold_err = 0;
        busy_after = 1'b1; timed_out = 1'b0; rst_snap = '1;
        ld_valid = 1'b0; m_ready_f = 1'b0; m_ready_x = 1'b0; s_valid_y = 1'b0;
        s_data_y = yval;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_ok = busy && m_valid_f && m_valid_x && s_ready_y;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0 && c == done_cycle + 1) begin
                busy_after = busy;
                finished = 1'b1;
                break;
            end
            if (pf_stall && (!m_valid_f || m_data_f !== pf_data)) stab_err++;
            if (px_stall && (!m_valid_x || m_data_x !== px_data)) stab_err++;
            if (y_beats >= 97 && s_ready_y) y_extra_err++;
            if (x_stall_idx >= 0 && x_beats == x_stall_idx && y_beats >= 97) begin
                hold_cycles++;
                if (!busy || done || !m_valid_x) hold_err++;
            end
            if (reset_at_x >= 0 && x_beats == reset_at_x) begin
                reset = 1'b0;
                #1;
                rst_snap = {busy, done, m_valid_f, m_valid_x, s_ready_y,
                            m_data_f, m_data_x, y_count, y_sum};
                #2;
                reset = 1'b1;
                finished = 1'b1;
                break;
            end
            if (c == poke_c) begin
                start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b1;
                ld_addr = 7'd5; ld_data = ~xmem[5];
            end else begin
                start = 1'b0; ld_valid = 1'b0;
            end
            m_ready_f = f_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready_x = ((c % x_period) == 0);
            if (x_stall_idx >= 0 && x_beats == x_stall_idx && (y_beats < 97 || stall_cnt < 10)) begin
                m_ready_x = 1'b0;
                if (y_beats >= 97) stall_cnt++;
            end
            if (y_last_with_x && y_beats >= 96)
                s_valid_y = m_valid_x && m_ready_x && (x_beats == 127);
            else if (y_rand)
                s_valid_y = 1'($urandom_range(0, 1));
            else
                s_valid_y = 1'b1;
            if (m_valid_f && m_ready_f) begin
                if (f_beats >= 32 || m_data_f !== fmem[f_beats]) f_ord_err++;
                f_beats++;
                f_last_c = c;
            end
            if (m_valid_x && m_ready_x) begin
                if (x_beats >= 128 || m_data_x !== xmem[x_beats]) x_ord_err++;
                x_beats++;
                x_last_c = c;
            end
            if (s_valid_y && s_ready_y) begin
                y_beats++;
                y_last_c = c;
            end
            pf_stall = m_valid_f && !m_ready_f; pf_data = m_data_f;
            px_stall = m_valid_x && !m_ready_x; px_data = m_data_x;
            tick();
        end
        start = 1'b0; ld_valid = 1'b0; s_valid_y = 1'b0; m_ready_f = 1'b0; m_ready_x = 1'b0;
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 7'd0; ld_data = 8'd0;
        start = 1'b0; m_ready_f = 1'b0; m_ready_x = 1'b0; s_valid_y = 1'b0; s_data_y = 21'd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b want 00", {busy, done}); else n_pass++;
        n_chk++; if ({m_valid_f, m_valid_x, s_ready_y} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {m_valid_f, m_valid_x, s_ready_y}); else n_pass++;
        n_chk++; if ({m_data_f, m_data_x} !== 16'h0000) $display("FAIL rst_data: got %h want 0000", {m_data_f, m_data_x}); else n_pass++;
        n_chk++; if (y_count !== 7'd0) $display("FAIL rst_y_count: got %0d want 0", y_count); else n_pass++;
        n_chk++; if (y_sum !== 28'd0) $display("FAIL rst_y_sum: got %0d want 0", y_sum); else n_pass++;
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_unit_weights();
        load_bufs(0, 8'd1);
        run_stream(1, 1'b0, 1'b0, 21'd32, -1, 1'b0, -1, -1);
        n_chk++; if (timed_out !== 1'b0) $display("FAIL unit_timeout: got %0d want 0", timed_out); else n_pass++;
        n_chk++; if (start_ok !== 1'b1) $display("FAIL unit_start_latency: got %0d want 1", start_ok); else n_pass++;
        n_chk++; if (f_beats !== 32) $display("FAIL unit_f_beats: got %0d want 32", f_beats); else n_pass++;
        n_chk++; if (x_beats !== 128) $display("FAIL unit_x_beats: got %0d want 128", x_beats); else n_pass++;
        n_chk++; if (f_last_c !== 31) $display("FAIL unit_f_throughput: got %0d want 31", f_last_c); else n_pass++;
        n_chk++; if (x_last_c !== 127) $display("FAIL unit_x_throughput: got %0d want 127", x_last_c); else n_pass++;
        n_chk++; if (y_count !== 7'd97) $display("FAIL unit_y_count: got %0d want 97", y_count); else n_pass++;
        n_chk++; if (y_sum !== 28'd3104) $display("FAIL unit_y_sum: got %0d want 3104", y_sum); else n_pass++;
        n_chk++; if (done_pulses !== 1) $display("FAIL unit_done_pulses: got %0d want 1", done_pulses); else n_pass++;
        n_chk++; if (done_cycle !== 128) $display("FAIL unit_done_cycle: got %0d want 128", done_cycle); else n_pass++;
        n_chk++; if (busy_after !== 1'b0) $display("FAIL unit_busy_after_done: got %0d want 0", busy_after); else n_pass++;
    endtask

    task automatic test_signed_extremes();
        load_bufs(0, 8'h80);
        run_stream(1, 1'b0, 1'b0, 21'd524288, -1, 1'b0, -1, -1);
        n_chk++; if (timed_out !== 1'b0) $display("FAIL ext_timeout: got %0d want 0", timed_out); else n_pass++;
        n_chk++; if (f_ord_err !== 0) $display("FAIL ext_f_data_80: got %0d bad beats want 0", f_ord_err); else n_pass++;
        n_chk++; if (x_ord_err !== 0) $display("FAIL ext_x_data_80: got %0d bad beats want 0", x_ord_err); else n_pass++;
        n_chk++; if (y_sum !== 28'd50855936) $display("FAIL ext_y_sum: got %0d want 50855936", y_sum); else n_pass++;
    endtask

    task automatic test_backpressure();
        load_bufs(1, 8'd0);
        run_stream(3, 1'b1, 1'b1, -21'sd5, -1, 1'b0, -1, -1);
        n_chk++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %0d want 0", timed_out); else n_pass++;
        n_chk++; if (stab_err !== 0) $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", stab_err); else n_pass++;
        n_chk++; if (f_ord_err !== 0 || f_beats !== 32) $display("FAIL bp_f_order: got %0d errs %0d beats want 0 errs 32 beats", f_ord_err, f_beats); else n_pass++;
        n_chk++; if (x_ord_err !== 0 || x_beats !== 128) $display("FAIL bp_x_order: got %0d errs %0d beats want 0 errs 128 beats", x_ord_err, x_beats); else n_pass++;
        n_chk++; if (y_beats !== 97) $display("FAIL bp_y_beats: got %0d want 97", y_beats); else n_pass++;
        n_chk++; if (y_extra_err !== 0) $display("FAIL bp_y_ready_after_97: got %0d want 0", y_extra_err); else n_pass++;
        n_chk++; if (y_count !== 7'd97) $display("FAIL bp_y_count: got %0d want 97", y_count); else n_pass++;
        n_chk++; if (y_sum !== 28'hFFFFE1B) $display("FAIL bp_y_sum: got %h want fffffe1b(-485)", y_sum); else n_pass++;
        n_chk++; if (s_ready_y !== 1'b0) $display("FAIL bp_s_ready_idle: got %0d want 0", s_ready_y); else n_pass++;
    endtask

    task automatic test_ignored_requests();
        run_stream(1, 1'b0, 1'b0, 21'd1, -1, 1'b0, 3, -1);
        n_chk++; if (x_ord_err !== 0 || x_beats !== 128) $display("FAIL ign_no_restart: got %0d errs %0d beats want 0 errs 128 beats", x_ord_err, x_beats); else n_pass++;
        n_chk++; if (done_pulses !== 1) $display("FAIL ign_done_pulses: got %0d want 1", done_pulses); else n_pass++;
        n_chk++; if (y_count !== 7'd97) $display("FAIL ign_y_count: got %0d want 97", y_count); else n_pass++;
        run_stream(1, 1'b0, 1'b0, 21'd1, -1, 1'b0, -1, -1);
        n_chk++; if (x_ord_err !== 0) $display("FAIL ign_buffer_unchanged: got %0d errs want 0", x_ord_err); else n_pass++;
        n_chk++; if (y_sum !== 28'd97) $display("FAIL ign_rerun_sum: got %0d want 97", y_sum); else n_pass++;
    endtask

    task automatic test_ordering_corner();
        run_stream(1, 1'b0, 1'b0, 21'd2, 100, 1'b0, -1, -1);
        n_chk++; if (hold_cycles !== 11) $display("FAIL ord_hold_cycles: got %0d want 11", hold_cycles); else n_pass++;
        n_chk++; if (hold_err !== 0) $display("FAIL ord_stay_stream: got %0d bad cycles want 0", hold_err); else n_pass++;
        n_chk++; if (x_last_c !== 137 || done_cycle !== 138) $display("FAIL ord_done_after_x: got x_last %0d done %0d want 137 138", x_last_c, done_cycle); else n_pass++;
        run_stream(1, 1'b0, 1'b0, 21'd3, -1, 1'b1, -1, -1);
        n_chk++; if (y_last_c !== 127 || x_last_c !== 127) $display("FAIL ord_same_cycle_setup: got y %0d x %0d want 127 127", y_last_c, x_last_c); else n_pass++;
        n_chk++; if (done_cycle !== 128) $display("FAIL ord_same_cycle_done: got %0d want 128", done_cycle); else n_pass++;
        n_chk++; if (y_sum !== 28'd291) $display("FAIL ord_same_cycle_sum: got %0d want 291", y_sum); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        run_stream(1, 1'b0, 1'b0, 21'd1, -1, 1'b0, -1, 60);
        n_chk++; if (rst_snap !== 56'd0) $display("FAIL midrst_outputs: got %h want 0", rst_snap); else n_pass++;
        tick();
        run_stream(1, 1'b0, 1'b0, 21'd7, -1, 1'b0, -1, -1);
        n_chk++; if (start_ok !== 1'b1) $display("FAIL midrst_restart: got %0d want 1", start_ok); else n_pass++;
        n_chk++; if (f_ord_err !== 0 || x_ord_err !== 0) $display("FAIL midrst_order: got f %0d x %0d errs want 0 0", f_ord_err, x_ord_err); else n_pass++;
        n_chk++; if (y_sum !== 28'd679) $display("FAIL midrst_y_sum: got %0d want 679", y_sum); else n_pass++;
        n_chk++; if (done_cycle !== 128) $display("FAIL midrst_done_cycle: got %0d want 128", done_cycle); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unit_weights();
        test_signed_extremes();
        test_backpressure();
        test_ignored_requests();
        test_ordering_corner();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
